ifft_tf_mult: RTL and testbench
===============================

# ifft_tf_mult

Streaming twiddle-factor multiplier for the 32-point IFFT datapath. It sits after a radix-2 butterfly stage and drives the address port of the 8-entry W32^(2k) twiddle ROM from its own 3-bit sample counter. It consumes the ROM's combinational Q1.10 twiddle output and multiplies each incoming complex sample by it in a 3-stage pipeline. Outputs are rounded and saturated, then passed to the next butterfly stage.

## Interface

Parameters:
- DW, 16: sample width, real and imag each, signed two's complement.
- TW, 12: twiddle width, signed Q1.10, where 1024 = 1.0.
- CONJ, 1: 1 = negate the ROM imag part (IFFT kernel W^-n); 0 = use the ROM value as-is (FFT).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present this cycle.
- in_sop  in  1  first sample of a frame; qualified by in_valid.
- in_tw_en  in  1  1 = multiply by the ROM twiddle; 0 = multiply by W^0 (pass-through with full latency).
- in_real, in_imag  in  DW  input sample.
- tf_addr  out  3  twiddle ROM address; registered counter value.
- tf_real, tf_imag  in  TW  ROM output for tf_addr, combinational.
- out_valid  out  1  result valid.
- out_sop  out  1  in_sop delayed with the data.
- out_real, out_imag  out  DW  rounded and saturated product.
- ovf  out  1  sticky saturation flag.

## Operation

Address counter (cnt, 3 bits, drives tf_addr directly):
- Effective address for an accepted sample: 0 if in_sop=1, otherwise cnt.
- On a cycle with in_valid=1 and in_tw_en=1: cnt <= effective address + 1, modulo 8, so 7 wraps to 0.
- On a cycle with in_valid=1 and in_tw_en=0: if in_sop=1, cnt <= 0; otherwise cnt holds.
- On a cycle with in_valid=0: cnt holds, and in_sop is ignored.
- Because tf_addr = cnt, the ROM output is valid in the same cycle as the sample. When in_sop=1 overrides a nonzero cnt, the block uses the constant W^0 = (1024, 0) instead of tf_real/tf_imag.

Twiddle select for each accepted sample:
- (c, d) = (1024, 0) when in_tw_en=0 or the in_sop override applies.
- Otherwise (c, d) = (tf_real, CONJ ? -tf_imag : tf_imag).
- Negating is always safe: the ROM imag range is -1024..0, so -tf_imag never overflows TW bits.

Arithmetic, for input a + jb:
- Stage 1 registers a, b, c, d, valid and sop.
- Stage 2 registers the four signed products ac, bd, ad, bc, each DW+TW = 28 bits.
- Stage 3 forms re = ac - bd and im = ad + bc at 29 bits each.
- Rounding is round-half-up: (x + 512) >>> 10, arithmetic shift.
- Each result saturates to [-32768, 32767]. out_real/out_imag are registered.
- ovf is set when either component saturates on a valid output. It clears on reset or when a valid output with out_sop=1 does not itself saturate.
- There is no backpressure. Gaps in in_valid propagate as bubbles.

## Timing

- Latency is exactly 3 cycles: a sample accepted at edge N appears on out_* with out_valid=1 after edge N+3.
- Throughput is one sample per cycle.
- out_valid and out_sop are the input qualifiers delayed by 3. out_sop is always 0 when out_valid=0.
- out_real/out_imag hold their last value when out_valid=0.
- Reset (asynchronous, takes effect immediately) clears to 0: cnt/tf_addr, all pipeline data and valid/sop registers, out_valid, out_sop, out_real, out_imag, ovf. Any sample in flight is discarded.
- When reset is asserted mid-frame, the first sample after release uses address 0.
- When in_sop and in_tw_en=1 occur together, address 0 is used and the next accepted twiddled sample uses address 1.

## Test plan

- Reset, then 8 consecutive twiddled samples with in_sop on the first: tf_addr steps 0..7. A 9th sample uses address 0 (wrap).
- Pass-through: input (1234, -567) with in_tw_en=0 -> output (1234, -567) exactly, 3 cycles later, ovf=0. Also check cnt is unchanged.
- Address 1 with CONJ=1 (ROM 946/-392, so d=+392): input (1000, 0) -> output (924, 383). With CONJ=0 -> (924, -383).
- Address 4 with CONJ=1 (d=+1024): input (100, 200) -> output (-200, 100).
- Saturation at address 6 with CONJ=1: input (32767, 32767) -> output (-32768, 0) and ovf=1. ovf stays 1 until a non-saturating sop output.
- Bubbles and reset: insert in_valid=0 gaps and check cnt holds and out_valid gaps match. Assert rst mid-frame: all outputs go to 0 immediately, and the next sop frame restarts at address 0.

Source files
------------

// File: rtl/ifft_tf_mult_if.sv
// Stream and twiddle-ROM signals of the IFFT twiddle multiplier.
// The slave side is the multiplier; the master side is its environment (upstream stage, ROM, downstream stage).
interface ifft_tf_mult_if #(
  parameter int DW = 16,
  parameter int TW = 12
);
  logic                 in_valid;
  logic                 in_sop;
  logic                 in_tw_en;
  logic signed [DW-1:0] in_real;
  logic signed [DW-1:0] in_imag;
  logic [2:0]           tf_addr;
  logic signed [TW-1:0] tf_real;
  logic signed [TW-1:0] tf_imag;
  logic                 out_valid;
  logic                 out_sop;
  logic signed [DW-1:0] out_real;
  logic signed [DW-1:0] out_imag;
  logic                 ovf;

  modport master (
    output in_valid, in_sop, in_tw_en, in_real, in_imag, tf_real, tf_imag,
    input  tf_addr, out_valid, out_sop, out_real, out_imag, ovf
  );

  modport slave (
    input  in_valid, in_sop, in_tw_en, in_real, in_imag, tf_real, tf_imag,
    output tf_addr, out_valid, out_sop, out_real, out_imag, ovf
  );
endinterface

// File: rtl/ifft_tf_mult.sv
// Streaming complex multiply by the W32^(2k) twiddle addressed from an internal sample counter.
// Pipeline: operand regs -> product regs -> sum regs -> rounded/saturated output regs.
module ifft_tf_mult #(
  parameter int DW   = 16,
  parameter int TW   = 12,
  parameter bit CONJ = 1'b1
) (
  input logic          clk,
  input logic          rst,
  ifft_tf_mult_if.slave bus
);
  localparam int PW = DW + TW;
  localparam int SW = PW + 1;
  localparam logic signed [TW-1:0] ONE  = TW'(1024);
  localparam logic signed [SW-1:0] HALF = SW'(512);
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (DW - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  logic [2:0]           cnt_q, cnt_d;
  logic                 s1_valid_q, s1_valid_d, s1_sop_q, s1_sop_d;
  logic signed [DW-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic signed [TW-1:0] s1_c_q, s1_c_d, s1_d_q, s1_d_d;
  logic                 s2_valid_q, s2_valid_d, s2_sop_q, s2_sop_d;
  logic signed [PW-1:0] s2_ac_q, s2_ac_d, s2_bd_q, s2_bd_d;
  logic signed [PW-1:0] s2_ad_q, s2_ad_d, s2_bc_q, s2_bc_d;
  logic                 s3_valid_q, s3_valid_d, s3_sop_q, s3_sop_d;
  logic signed [SW-1:0] s3_re_q, s3_re_d, s3_im_q, s3_im_d;
  logic                 out_valid_q, out_valid_d, out_sop_q, out_sop_d;
  logic signed [DW-1:0] out_real_q, out_real_d, out_imag_q, out_imag_d;
  logic                 ovf_q, ovf_d;

  logic [2:0]           eff_addr;
  logic                 use_unity;
  logic signed [SW-1:0] re_rnd, im_rnd;
  logic                 re_sat, im_sat;

  always_comb begin
    // A frame start always restarts at address 0, whose twiddle is exactly W^0.
    eff_addr  = bus.in_sop ? 3'd0 : cnt_q;
    use_unity = !bus.in_tw_en || bus.in_sop;
    cnt_d     = cnt_q;
    if (bus.in_valid) begin
      if (bus.in_tw_en)
        cnt_d = eff_addr + 3'd1;
      else if (bus.in_sop)
        cnt_d = 3'd0;
    end

    s1_valid_d = bus.in_valid;
    s1_sop_d   = bus.in_valid && bus.in_sop;
    s1_a_d     = bus.in_real;
    s1_b_d     = bus.in_imag;
    s1_c_d     = use_unity ? ONE : bus.tf_real;
    s1_d_d     = use_unity ? '0 : (CONJ ? -bus.tf_imag : bus.tf_imag);

    s2_valid_d = s1_valid_q;
    s2_sop_d   = s1_sop_q;
    s2_ac_d    = PW'(s1_a_q) * PW'(s1_c_q);
    s2_bd_d    = PW'(s1_b_q) * PW'(s1_d_q);
    s2_ad_d    = PW'(s1_a_q) * PW'(s1_d_q);
    s2_bc_d    = PW'(s1_b_q) * PW'(s1_c_q);

    s3_valid_d = s2_valid_q;
    s3_sop_d   = s2_sop_q;
    s3_re_d    = SW'(s2_ac_q) - SW'(s2_bd_q);
    s3_im_d    = SW'(s2_ad_q) + SW'(s2_bc_q);

    // Round half up, then clamp into the output range.
    re_rnd = (s3_re_q + HALF) >>> 10;
    im_rnd = (s3_im_q + HALF) >>> 10;
    re_sat = (re_rnd > MAXV) || (re_rnd < MINV);
    im_sat = (im_rnd > MAXV) || (im_rnd < MINV);

    out_valid_d = s3_valid_q;
    out_sop_d   = s3_sop_q;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;
    ovf_d       = ovf_q;
    if (s3_valid_q) begin
      out_real_d = (re_rnd > MAXV) ? DW'(MAXV) : ((re_rnd < MINV) ? DW'(MINV) : re_rnd[DW-1:0]);
      out_imag_d = (im_rnd > MAXV) ? DW'(MAXV) : ((im_rnd < MINV) ? DW'(MINV) : im_rnd[DW-1:0]);
      if (re_sat || im_sat)
        ovf_d = 1'b1;
      else if (s3_sop_q)
        ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_sop_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= '0;
      s1_d_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_sop_q    <= 1'b0;
      s2_ac_q     <= '0;
      s2_bd_q     <= '0;
      s2_ad_q     <= '0;
      s2_bc_q     <= '0;
      s3_valid_q  <= 1'b0;
      s3_sop_q    <= 1'b0;
      s3_re_q     <= '0;
      s3_im_q     <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_sop_q    <= s1_sop_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_c_q      <= s1_c_d;
      s1_d_q      <= s1_d_d;
      s2_valid_q  <= s2_valid_d;
      s2_sop_q    <= s2_sop_d;
      s2_ac_q     <= s2_ac_d;
      s2_bd_q     <= s2_bd_d;
      s2_ad_q     <= s2_ad_d;
      s2_bc_q     <= s2_bc_d;
      s3_valid_q  <= s3_valid_d;
      s3_sop_q    <= s3_sop_d;
      s3_re_q     <= s3_re_d;
      s3_im_q     <= s3_im_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.tf_addr   = cnt_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_real  = out_real_q;
  assign bus.out_imag  = out_imag_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_ifft_tf_mult.sv
// Directed + random stimulus for ifft_tf_mult in IFFT (CONJ=1) and FFT (CONJ=0) builds side by side.
// Expected results are queued at drive time and retired four negedges later, when the DUT shows them.
module tb_ifft_tf_mult;
  logic clk = 1'b0;
  logic rst = 1'b1;

  ifft_tf_mult_if #(.DW(16), .TW(12)) bus1 ();
  ifft_tf_mult_if #(.DW(16), .TW(12)) bus0 ();

  ifft_tf_mult #(.DW(16), .TW(12), .CONJ(1'b1)) u_dut_ifft (.clk(clk), .rst(rst), .bus(bus1));
  ifft_tf_mult #(.DW(16), .TW(12), .CONJ(1'b0)) u_dut_fft  (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;

  // W32^(2k) = exp(-j*pi*k/8) in Q1.10
  int rom_re [8] = '{1024, 946, 724, 392, 0, -392, -724, -946};
  int rom_im [8] = '{0, -392, -724, -946, -1024, -946, -724, -392};

  assign bus1.tf_real = 12'(rom_re[bus1.tf_addr]);
  assign bus1.tf_imag = 12'(rom_im[bus1.tf_addr]);
  assign bus0.tf_real = 12'(rom_re[bus0.tf_addr]);
  assign bus0.tf_imag = 12'(rom_im[bus0.tf_addr]);

  typedef struct {
    bit valid;
    bit sop;
    int re1, im1, re0, im0;
    bit sat1, sat0;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   model_cnt = 0;
  int   last_re1 = 0, last_im1 = 0, last_re0 = 0, last_im0 = 0;
  bit   ovf1 = 1'b0, ovf0 = 1'b0;

  task automatic chk(input string tag, input logic signed [31:0] observed,
                     input logic signed [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int clamp(input longint x, inout bit sat);
    if (x > 32767) begin
      sat = 1'b1;
      return 32767;
    end
    if (x < -32768) begin
      sat = 1'b1;
      return -32768;
    end
    return int'(x);
  endfunction

  function automatic void model(input int a, input int b, input int k, input bit unity,
                                input bit conj, output int re, output int im, output bit sat);
    longint c, d, pr, pi;
    c   = unity ? 1024 : rom_re[k];
    d   = unity ? 0 : (conj ? -rom_im[k] : rom_im[k]);
    pr  = longint'(a) * c - longint'(b) * d;
    pi  = longint'(a) * d + longint'(b) * c;
    sat = 1'b0;
    re  = clamp((pr + 512) >>> 10, sat);
    im  = clamp((pi + 512) >>> 10, sat);
  endfunction

  task automatic resetModel();
    exp_t e;
    model_cnt = 0;
    last_re1 = 0; last_im1 = 0; last_re0 = 0; last_im0 = 0;
    ovf1 = 1'b0; ovf0 = 1'b0;
    sb.delete();
    e = '{valid: 1'b0, sop: 1'b0, re1: 0, im1: 0, re0: 0, im0: 0, sat1: 1'b0, sat0: 1'b0};
    repeat (4) sb.push_back(e);
  endtask

  task automatic idleInputs();
    bus1.in_valid = 1'b0; bus1.in_sop = 1'b0; bus1.in_tw_en = 1'b0;
    bus1.in_real = '0; bus1.in_imag = '0;
    bus0.in_valid = 1'b0; bus0.in_sop = 1'b0; bus0.in_tw_en = 1'b0;
    bus0.in_real = '0; bus0.in_imag = '0;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() >= 4) begin
      e = sb.pop_front();
      if (e.valid) begin
        last_re1 = e.re1; last_im1 = e.im1; last_re0 = e.re0; last_im0 = e.im0;
        if (e.sat1) ovf1 = 1'b1; else if (e.sop) ovf1 = 1'b0;
        if (e.sat0) ovf0 = 1'b1; else if (e.sop) ovf0 = 1'b0;
      end
      chk("out_valid", bus1.out_valid, e.valid);
      chk("out_sop", bus1.out_sop, e.sop);
      chk("out_real", bus1.out_real, last_re1);
      chk("out_imag", bus1.out_imag, last_im1);
      chk("ovf", bus1.ovf, ovf1);
      chk("fft_out_valid", bus0.out_valid, e.valid);
      chk("fft_out_real", bus0.out_real, last_re0);
      chk("fft_out_imag", bus0.out_imag, last_im0);
      chk("fft_ovf", bus0.ovf, ovf0);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit sop, input bit tw, input int re, input int im);
    exp_t e;
    int   k;
    @(negedge clk);
    checkOutput();
    chk("tf_addr", bus1.tf_addr, model_cnt);
    chk("fft_tf_addr", bus0.tf_addr, model_cnt);
    bus1.in_valid = v; bus1.in_sop = sop; bus1.in_tw_en = tw;
    bus1.in_real = 16'(re); bus1.in_imag = 16'(im);
    bus0.in_valid = v; bus0.in_sop = sop; bus0.in_tw_en = tw;
    bus0.in_real = 16'(re); bus0.in_imag = 16'(im);
    k = sop ? 0 : model_cnt;
    e.valid = v;
    e.sop   = v && sop;
    model(re, im, k, !tw || sop, 1'b1, e.re1, e.im1, e.sat1);
    model(re, im, k, !tw || sop, 1'b0, e.re0, e.im0, e.sat0);
    sb.push_back(e);
    if (v) begin
      if (tw) model_cnt = (k + 1) % 8;
      else if (sop) model_cnt = 0;
    end
  endtask

  task automatic checkResetState();
    chk("rst_tf_addr", bus1.tf_addr, 0);
    chk("rst_out_valid", bus1.out_valid, 0);
    chk("rst_out_sop", bus1.out_sop, 0);
    chk("rst_out_real", bus1.out_real, 0);
    chk("rst_out_imag", bus1.out_imag, 0);
    chk("rst_ovf", bus1.ovf, 0);
    chk("rst_fft_out_real", bus0.out_real, 0);
  endtask

  initial begin
    idleInputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkResetState();
    rst = 1'b0;
    resetModel();

    // Full frame over addresses 0..7, then the wrap back to 0
    applyStimulus(1, 1, 1, 500, -300);
    applyStimulus(1, 0, 1, 1000, 0);
    applyStimulus(1, 0, 1, -2000, 1500);
    applyStimulus(1, 0, 1, 3000, 3000);
    applyStimulus(1, 0, 1, 100, 200);
    applyStimulus(1, 0, 1, -32768, 12345);
    applyStimulus(1, 0, 1, 32767, 32767);
    applyStimulus(1, 0, 1, 7, -9);
    applyStimulus(1, 0, 1, 1000, 1000);

    // Bubbles with a stray sop, pass-through, then a clean sop that clears ovf
    applyStimulus(0, 1, 1, 111, 222);
    applyStimulus(0, 0, 1, 333, 444);
    applyStimulus(1, 0, 0, 1234, -567);
    applyStimulus(1, 1, 0, 20000, -20000);
    applyStimulus(1, 0, 1, -5, 5);
    applyStimulus(1, 0, 1, 4096, -4096);

    // sop override of a nonzero counter, followed by address 1
    applyStimulus(1, 1, 1, 30000, -30000);
    applyStimulus(1, 0, 1, 1000, 0);
    applyStimulus(1, 0, 1, -32768, -32768);

    for (int i = 0; i < 24; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 65535)) - 32768);

    // Mid-frame reset with ovf set and samples in flight
    applyStimulus(1, 1, 1, 1, 1);
    applyStimulus(1, 0, 1, 32767, 32767);
    applyStimulus(1, 0, 1, 100, 100);
    applyStimulus(1, 0, 1, 100, 100);
    applyStimulus(1, 0, 1, 100, 100);
    applyStimulus(1, 0, 1, 100, 100);
    applyStimulus(1, 0, 1, 100, 100);
    #2 rst = 1'b1;
    #1 checkResetState();
    idleInputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resetModel();

    applyStimulus(1, 0, 1, 1000, 0);
    applyStimulus(1, 1, 1, -1000, 2000);
    applyStimulus(1, 0, 1, 1000, 0);
    applyStimulus(1, 0, 1, 250, -250);
    repeat (5) applyStimulus(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
